// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load and frame strobes
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_frame,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             out_bit;
    logic             last_data;
`ifdef PISO_PARITY_EN
    logic             par, par_next;
`endif

    assign out_bit   = LSB_FIRST ? sr[0] : sr[WIDTH-1];
    assign last_data = (cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        pready     = 1'b0;
        so         = 1'b0;
        so_frame   = 1'b0;
        so_last    = 1'b0;
        busy       = 1'b0;
`ifdef PISO_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                pready = 1'b1;
            end
            SHIFT: begin
                so       = out_bit;
                so_frame = 1'b1;
                busy     = 1'b1;
`ifndef PISO_PARITY_EN
                so_last  = last_data;
                pready   = last_data && shift_en;
`endif
                if (shift_en) begin
                    sr_next  = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
                    cnt_next = cnt + CW'(1);
                    if (last_data) begin
`ifdef PISO_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                so       = par;
                so_frame = 1'b1;
                so_last  = 1'b1;
                busy     = 1'b1;
                pready   = shift_en;
                if (shift_en) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        // Accepting on the final consuming edge chains the next frame with no idle bit.
        if (pvalid && pready) begin
            sr_next    = pdata;
            cnt_next   = '0;
            state_next = SHIFT;
`ifdef PISO_PARITY_EN
            par_next   = ^pdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
`ifdef PISO_PARITY_EN
            par   <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed bench for piso_serializer, LSB-first and MSB-first instances
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam logic NP = 1'b0;
`else
    localparam logic NP = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] pdata = '0;
    logic       pvalid_a = 1'b0;
    logic       pvalid_b = 1'b0;
    logic       shift_en = 1'b0;
    logic       pready_a, so_a, frame_a, last_a, busy_a;
    logic       pready_b, so_b, frame_b, last_b, busy_b;
    logic [4:0] oa, ob;
    int         total = 0;
    int         bad = 0;

    piso_serializer #(.WIDTH(5), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .pdata(pdata), .pvalid(pvalid_a), .pready(pready_a),
        .shift_en(shift_en), .so(so_a), .so_frame(frame_a), .so_last(last_a), .busy(busy_a)
    );

    piso_serializer #(.WIDTH(5), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .pdata(pdata), .pvalid(pvalid_b), .pready(pready_b),
        .shift_en(shift_en), .so(so_b), .so_frame(frame_b), .so_last(last_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Observation vector layout: {so, so_frame, so_last, busy, pready}
    assign oa = {so_a, frame_a, last_a, busy_a, pready_a};
    assign ob = {so_b, frame_b, last_b, busy_b, pready_b};

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit sel_b, input logic en, input logic [4:0] exp);
        shift_en = en;
        @(negedge clk);
        chk(tag, sel_b ? ob : oa, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("rst_a", oa, 5'b00001);
        chk("rst_b", ob, 5'b00001);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // LSB-first 5'b10110 with continuous enable
        pdata = 5'b10110; pvalid_a = 1'b1;
        step("lsb_load", 0, 1'b1, 5'b00001);
        pvalid_a = 1'b0; pdata = 5'b01001;
        step("lsb_b0", 0, 1'b1, 5'b01010);
        step("lsb_b1", 0, 1'b1, 5'b11010);
        step("lsb_b2", 0, 1'b1, 5'b11010);
        step("lsb_b3", 0, 1'b1, 5'b01010);
        step("lsb_b4", 0, 1'b1, {1'b1, 1'b1, NP, 1'b1, NP});
`ifdef PISO_PARITY_EN
        step("lsb_par", 0, 1'b1, 5'b11111);
`endif
        step("lsb_idle", 0, 1'b0, 5'b00001);

        // MSB-first 5'b10110 with enable gaps
        pdata = 5'b10110; pvalid_b = 1'b1;
        step("msb_load", 1, 1'b1, 5'b00001);
        pvalid_b = 1'b0;
        step("msb_c1", 1, 1'b0, 5'b11010);
        step("msb_c2", 1, 1'b0, 5'b11010);
        step("msb_c3", 1, 1'b1, 5'b11010);
        step("msb_c4", 1, 1'b1, 5'b01010);
        step("msb_c5", 1, 1'b0, 5'b11010);
        step("msb_c6", 1, 1'b1, 5'b11010);
        step("msb_c7", 1, 1'b1, 5'b11010);
        step("msb_c8", 1, 1'b1, {1'b0, 1'b1, NP, 1'b1, NP});
`ifdef PISO_PARITY_EN
        step("msb_par", 1, 1'b1, 5'b11111);
`endif
        step("msb_idle", 1, 1'b1, 5'b00001);

        // Back-to-back 5'h15 then 5'h0A, pdata wiggling mid-frame
        pdata = 5'h15; pvalid_a = 1'b1;
        step("bb_load", 0, 1'b1, 5'b00001);
        pdata = 5'h0A;
        step("bb_w0b0", 0, 1'b1, 5'b11010);
        step("bb_w0b1", 0, 1'b1, 5'b01010);
        step("bb_w0b2", 0, 1'b1, 5'b11010);
        step("bb_w0b3", 0, 1'b1, 5'b01010);
        step("bb_w0b4", 0, 1'b1, {1'b1, 1'b1, NP, 1'b1, NP});
`ifdef PISO_PARITY_EN
        step("bb_w0par", 0, 1'b1, 5'b11111);
`endif
        step("bb_w1b0", 0, 1'b1, 5'b01010);
        pdata = 5'h1F;
        step("bb_w1b1", 0, 1'b1, 5'b11010);
        step("bb_w1b2", 0, 1'b1, 5'b01010);
        step("bb_w1b3", 0, 1'b1, 5'b11010);
        pvalid_a = 1'b0;
        step("bb_w1b4", 0, 1'b1, {1'b0, 1'b1, NP, 1'b1, NP});
`ifdef PISO_PARITY_EN
        step("bb_w1par", 0, 1'b1, 5'b01111);
`endif
        step("bb_idle", 0, 1'b1, 5'b00001);

`ifdef PISO_PARITY_EN
        pdata = 5'b00011; pvalid_a = 1'b1;
        step("par0_load", 0, 1'b1, 5'b00001);
        pvalid_a = 1'b0;
        step("par0_b0", 0, 1'b1, 5'b11010);
        step("par0_b1", 0, 1'b1, 5'b11010);
        step("par0_b2", 0, 1'b1, 5'b01010);
        step("par0_b3", 0, 1'b1, 5'b01010);
        step("par0_b4", 0, 1'b1, 5'b01010);
        step("par0_par", 0, 1'b1, 5'b01111);
        step("par0_idle", 0, 1'b0, 5'b00001);
`endif

        // Asynchronous reset mid-frame while so=1
        pdata = 5'b10110; pvalid_a = 1'b1;
        step("ar_load", 0, 1'b1, 5'b00001);
        pvalid_a = 1'b0;
        step("ar_b0", 0, 1'b1, 5'b01010);
        #2;
        chk("ar_pre", oa, 5'b11010);
        rst = 1'b0;
        #1;
        chk("ar_async", oa, 5'b00001);
        @(posedge clk);
        #1;
        chk("ar_held", oa, 5'b00001);
        rst = 1'b1;
        step("ar_post0", 0, 1'b1, 5'b00001);
        step("ar_post1", 0, 1'b1, 5'b00001);
        chk("ar_b_idle", ob, 5'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
